// File: rtl/etapa_ex_mem_if.sv
// etapa_ex_mem_if
// Handshake and data bundle between the execute stage and the memory stage.
//   ex_*   : instruction presented by the execute stage (ex_listo back to it)
//   flush  : squash of the execute-stage instruction
//   mem_*  : registered instruction offered to the memory stage (mem_listo back)
// Modports:
//   master : producer/consumer side (execute stage + memory stage, or a bench)
//   slave  : the etapa_ex_mem pipeline register
interface etapa_ex_mem_if #(
    parameter int unsigned N    = 32,
    parameter int unsigned RD_W = 4
);
    logic            ex_valido;
    logic            ex_listo;
    logic [N-1:0]    ex_C;
    logic [3:0]      ex_banderas;
    logic            ex_actBanderas;
    logic [2:0]      ex_cond;
    logic [RD_W-1:0] ex_rd;
    logic            ex_escribeReg;
    logic            flush;
    logic            mem_valido;
    logic            mem_listo;
    logic [N-1:0]    mem_C;
    logic [RD_W-1:0] mem_rd;
    logic            mem_escribeReg;
    logic            mem_ejecutada;

    modport master (
        output ex_valido, ex_C, ex_banderas, ex_actBanderas, ex_cond, ex_rd,
               ex_escribeReg, flush, mem_listo,
        input  ex_listo, mem_valido, mem_C, mem_rd, mem_escribeReg, mem_ejecutada
    );

    modport slave (
        input  ex_valido, ex_C, ex_banderas, ex_actBanderas, ex_cond, ex_rd,
               ex_escribeReg, flush, mem_listo,
        output ex_listo, mem_valido, mem_C, mem_rd, mem_escribeReg, mem_ejecutada
    );
endinterface

// File: rtl/etapa_ex_mem.sv
// etapa_ex_mem
// EX/MEM pipeline register plus the architectural flag register {N, Z, V, C}.
// Each instruction's condition code is evaluated against the committed flags;
// failed-condition instructions still travel down the pipe, but with
// mem_escribeReg=0 / mem_ejecutada=0, no flag write, and they bump a
// saturating counter.
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous, active-low reset
//   bus            : etapa_ex_mem_if.slave (ex_* in, mem_* out, flush)
//   banderas       : committed {N, Z, V, C}
//   cond_ok        : combinational condition result for bus.ex_cond
//   cuentaAnuladas : saturating count of condition-failed instructions
// Configuration macro: COND_EXEC_EN (defined = conditional execution;
// undefined = every instruction executes, counter fixed at 0).
module etapa_ex_mem #(
    parameter int unsigned N    = 32,
    parameter int unsigned RD_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    etapa_ex_mem_if.slave       bus,
    output logic [3:0]          banderas,
    output logic                cond_ok,
    output logic [15:0]         cuentaAnuladas
);
    logic transfer;

    // Depends only on registered state and mem_listo, never on ex_valido.
    assign bus.ex_listo = !bus.mem_valido || bus.mem_listo;
    assign transfer     = bus.ex_valido && bus.ex_listo && !bus.flush;

`ifdef COND_EXEC_EN
    logic fN, fZ, fV, fC;
    assign {fN, fZ, fV, fC} = banderas;

    always_comb begin
        cond_ok = 1'b1;
        case (bus.ex_cond)
            3'b000:  cond_ok = 1'b1;
            3'b001:  cond_ok = fZ;
            3'b010:  cond_ok = !fZ;
            3'b011:  cond_ok = (fN != fV);
            3'b100:  cond_ok = (fN == fV);
            3'b101:  cond_ok = !fZ && (fN == fV);
            3'b110:  cond_ok = fZ || (fN != fV);
            default: cond_ok = fC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cuentaAnuladas <= '0;
        end else if (transfer && !cond_ok && (cuentaAnuladas != '1)) begin
            cuentaAnuladas <= cuentaAnuladas + 16'd1;
        end
    end
`else
    logic unusedCond;
    assign unusedCond     = ^bus.ex_cond;
    assign cond_ok        = 1'b1;
    assign cuentaAnuladas = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.mem_valido     <= 1'b0;
            bus.mem_C          <= '0;
            bus.mem_rd         <= '0;
            bus.mem_escribeReg <= 1'b0;
            bus.mem_ejecutada  <= 1'b0;
            banderas           <= '0;
        end else if (bus.flush) begin
            bus.mem_valido <= 1'b0;
        end else if (transfer) begin
            bus.mem_valido     <= 1'b1;
            bus.mem_C          <= bus.ex_C;
            bus.mem_rd         <= bus.ex_rd;
            bus.mem_escribeReg <= bus.ex_escribeReg && cond_ok;
            bus.mem_ejecutada  <= cond_ok;
            if (bus.ex_actBanderas && cond_ok) begin
                banderas <= bus.ex_banderas;
            end
        end else if (bus.mem_valido && bus.mem_listo) begin
            bus.mem_valido <= 1'b0;
        end
    end
endmodule

// File: tb/tb_etapa_ex_mem.sv
module tb_etapa_ex_mem;
    localparam int unsigned N    = 32;
    localparam int unsigned RD_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  banderas;
    logic        cond_ok;
    logic [15:0] cuentaAnuladas;

    etapa_ex_mem_if #(.N(N), .RD_W(RD_W)) bus ();

    etapa_ex_mem #(.N(N), .RD_W(RD_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .banderas       (banderas),
        .cond_ok        (cond_ok),
        .cuentaAnuladas (cuentaAnuladas)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          mValid;
    logic [31:0] mC;
    logic [3:0]  mRd;
    bit          mEsc, mEjec;
    logic [3:0]  mFlags;
    int          mCnt;
    bit          lastStall;

    function automatic bit condHolds(input logic [2:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
        bit eq, lt;
        eq = f[2];
        lt = (f[3] != f[1]);
        case (c)
            3'd0: return 1'b1;
            3'd1: return eq;
            3'd2: return !eq;
            3'd3: return lt;
            3'd4: return !lt;
            3'd5: return !eq && !lt;
            3'd6: return eq || lt;
            default: return f[0];
        endcase
`else
        return 1'b1;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setIn(input bit v, input logic [31:0] c, input logic [3:0] f, input bit act,
                         input logic [2:0] cond, input logic [3:0] rd, input bit esc,
                         input bit fl, input bit listo);
        bus.ex_valido      = v;
        bus.ex_C           = c;
        bus.ex_banderas    = f;
        bus.ex_actBanderas = act;
        bus.ex_cond        = cond;
        bus.ex_rd          = rd;
        bus.ex_escribeReg  = esc;
        bus.flush          = fl;
        bus.mem_listo      = listo;
    endtask

    // Called just after a falling edge with inputs already driven: checks all
    // outputs against the model, advances the model, returns at next falling edge.
    task automatic cycle();
        bit expListo, ok;
        #1;
        expListo = !mValid || bus.mem_listo;
        ok = condHolds(bus.ex_cond, mFlags);
        chk("ex_listo", {31'd0, bus.ex_listo}, {31'd0, expListo});
        chk("cond_ok", {31'd0, cond_ok}, {31'd0, ok});
        chk("mem_valido", {31'd0, bus.mem_valido}, {31'd0, mValid});
        chk("mem_C", bus.mem_C, mC);
        chk("mem_rd", {28'd0, bus.mem_rd}, {28'd0, mRd});
        chk("mem_escribeReg", {31'd0, bus.mem_escribeReg}, {31'd0, mEsc});
        chk("mem_ejecutada", {31'd0, bus.mem_ejecutada}, {31'd0, mEjec});
        chk("banderas", {28'd0, banderas}, {28'd0, mFlags});
        chk("cuentaAnuladas", {16'd0, cuentaAnuladas}, mCnt);
        lastStall = rst && !bus.flush && bus.ex_valido && !expListo;
        @(posedge clk);
        if (!rst) begin
            mValid = 0; mC = '0; mRd = '0; mEsc = 0; mEjec = 0; mFlags = '0; mCnt = 0;
        end else if (bus.flush) begin
            mValid = 0;
        end else if (bus.ex_valido && expListo) begin
            mValid = 1;
            mC = bus.ex_C;
            mRd = bus.ex_rd;
            mEsc = bus.ex_escribeReg && ok;
            mEjec = ok;
            if (bus.ex_actBanderas && ok) mFlags = bus.ex_banderas;
            if (!ok && mCnt < 16'hFFFF) mCnt++;
        end else if (mValid && bus.mem_listo) begin
            mValid = 0;
        end
        vectors++;
        @(negedge clk);
    endtask

    initial begin
        int saved;
        bit condEn;
`ifdef COND_EXEC_EN
        condEn = 1;
`else
        condEn = 0;
`endif
        rst = 1'b0;
        setIn(0, '0, '0, 0, '0, '0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        mValid = 0; mC = '0; mRd = '0; mEsc = 0; mEjec = 0; mFlags = '0; mCnt = 0;

        // Reset then idle
        cycle();
        rst = 1'b1;
        cycle();
        chk("idle ex_listo", {31'd0, bus.ex_listo}, 32'd1);
        chk("idle mem_valido", {31'd0, bus.mem_valido}, 32'd0);
        chk("idle mem_C", bus.mem_C, 32'd0);
        chk("idle banderas", {28'd0, banderas}, 32'd0);
        chk("idle cuenta", {16'd0, cuentaAnuladas}, 32'd0);

        // Basic capture
        setIn(1, 32'h0000_0005, 4'b0000, 1, 3'b000, 4'd3, 1, 0, 1);
        cycle();
        setIn(0, '0, '0, 0, '0, '0, 0, 0, 1);
        #1;
        chk("basic mem_C", bus.mem_C, 32'd5);
        chk("basic mem_valido", {31'd0, bus.mem_valido}, 32'd1);
        chk("basic banderas", {28'd0, banderas}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        // Re-align: the model saw no cycle for the two idle edges above; drain happened
        mValid = 0;

        // Conditional pair
        setIn(1, 32'h11, 4'b0100, 1, 3'b000, 4'd1, 1, 0, 1);
        cycle();
        setIn(1, 32'h77, 4'b1000, 1, 3'b010, 4'd2, 1, 0, 1);
        cycle();
        setIn(0, '0, '0, 0, '0, '0, 0, 0, 0);
        #1;
        chk("pair mem_escribeReg", {31'd0, bus.mem_escribeReg}, condEn ? 32'd0 : 32'd1);
        chk("pair mem_ejecutada", {31'd0, bus.mem_ejecutada}, condEn ? 32'd0 : 32'd1);
        chk("pair banderas", {28'd0, banderas}, condEn ? 32'h4 : 32'h8);
        chk("pair cuenta", {16'd0, cuentaAnuladas}, condEn ? 32'd1 : 32'd0);

        // Backpressure: 3 stalled cycles
        setIn(1, 32'hAAAA, 4'b0011, 1, 3'b000, 4'd5, 1, 0, 0);
        repeat (3) begin
            cycle();
            chk("bp ex_listo", {31'd0, bus.ex_listo}, 32'd0);
            chk("bp mem_C", bus.mem_C, 32'h77);
            chk("bp banderas", {28'd0, banderas}, condEn ? 32'h4 : 32'h8);
        end
        bus.mem_listo = 1'b1;
        cycle();
        chk("bp release mem_C", bus.mem_C, 32'hAAAA);
        chk("bp release banderas", {28'd0, banderas}, 32'h3);

        // Flush
        saved = mCnt;
        setIn(1, 32'hDEAD, 4'b1111, 1, 3'b000, 4'd6, 1, 1, 1);
        cycle();
        setIn(0, '0, '0, 0, '0, '0, 0, 0, 1);
        #1;
        chk("flush mem_valido", {31'd0, bus.mem_valido}, 32'd0);
        chk("flush banderas", {28'd0, banderas}, 32'h3);
        chk("flush cuenta", {16'd0, cuentaAnuladas}, saved);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        // Counter saturation: EQ fails since Z=0 in flags 0011
        setIn(1, 32'h1, 4'b0000, 0, 3'b001, 4'd7, 1, 0, 1);
        if (condEn) begin
            while (mCnt < 16'hFFFE) cycle();
            chk("sat preload", {16'd0, cuentaAnuladas}, 32'hFFFE);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (i > 0) chk("sat cuenta", {16'd0, cuentaAnuladas}, condEn ? 32'hFFFF : 32'd0);
        end

        // Reset in the middle of a hold
        setIn(1, 32'h55, 4'b1010, 1, 3'b000, 4'd9, 1, 0, 1);
        cycle();
        bus.mem_listo = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        setIn(0, '0, '0, 0, '0, '0, 0, 0, 1);
        #1;
        chk("rst mem_valido", {31'd0, bus.mem_valido}, 32'd0);
        chk("rst mem_C", bus.mem_C, 32'd0);
        chk("rst banderas", {28'd0, banderas}, 32'd0);
        chk("rst cuenta", {16'd0, cuentaAnuladas}, 32'd0);
        chk("rst ex_listo", {31'd0, bus.ex_listo}, 32'd1);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        mValid = 0;
        lastStall = 0;

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            if (lastStall) begin
                bus.ex_valido = 1'b1;
            end else begin
                bus.ex_valido      = ($urandom_range(0, 3) != 0);
                bus.ex_C           = $urandom;
                bus.ex_banderas    = 4'($urandom);
                bus.ex_actBanderas = ($urandom_range(0, 1) != 0);
                bus.ex_cond        = 3'($urandom);
                bus.ex_rd          = 4'($urandom);
                bus.ex_escribeReg  = ($urandom_range(0, 1) != 0);
            end
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.mem_listo = ($urandom_range(0, 3) != 0);
            rst           = ($urandom_range(0, 99) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
